// File: rtl/inst_feeder_pkg.sv
// ---------------------------------------------------------------------------
// inst_feeder_pkg
// Shared constants and types for the symbolic instruction-fetch responder.
//   INSN_LEN      : width of an instruction word
//   RV_NOP        : canonical RISC-V NOP (addi x0,x0,0)
//   PC_LEN        : width of a fetch PC
//   fetch_entry_t : one queued response, {pc, insn}
// ---------------------------------------------------------------------------
package inst_feeder_pkg;

    localparam int INSN_LEN = 32;
    localparam int PC_LEN   = 32;

    localparam logic [INSN_LEN-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_LEN-1:0]   pc;
        logic [INSN_LEN-1:0] insn;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/inst_feeder_fifo.sv
// ---------------------------------------------------------------------------
// feeder_fifo
// Synchronous circular-buffer FIFO with flush, used as the outstanding
// response queue of inst_feeder.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   push_i/data_i : write one entry (caller guarantees !full_o)
//   pop_i         : drop the head entry (caller guarantees !empty_o)
//   flush_i       : discard every stored entry; a same-cycle push survives
//   full_o/empty_o: occupancy flags
//   head_o        : head entry, forced to 0 while empty
// ---------------------------------------------------------------------------
module feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]     mem_q [DEPTH];

    // The extra pointer MSB tells full apart from empty when the indices match.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        // Flush jumps the read pointer to the pre-push write pointer, so a
        // push in the same cycle becomes the only surviving entry.
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible until a push lands.
    always_ff @(posedge clk) begin
        if (rst_n && push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/inst_feeder.sv
// ---------------------------------------------------------------------------
// inst_feeder
// Symbolic instruction-fetch responder for the biriscv formal harness.
// Accepts fetch requests, captures the free symbolic word at acceptance and
// returns {pc, insn} responses in order. After MAX_INSNS symbolic words the
// responder substitutes canonical NOPs. The word that would be admitted is
// tapped out to the constraint checker.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   fetch_rd_i, fetch_pc_i      : fetch request and its PC
//   fetch_accept_o              : request accepted this cycle
//   fetch_valid_o               : response valid at queue head
//   fetch_instr_o, fetch_pc_o   : head response (0 when empty)
//   fetch_rsp_ready_i           : core consumes the head response
//   fetch_flush_i               : drop all queued responses
//   sym_insn_i                  : unconstrained symbolic word
//   chk_insn_o                  : word presented to the constraint checker
//   issued_cnt_o                : symbolic words issued so far
//   budget_done_o               : symbolic budget exhausted
// ---------------------------------------------------------------------------
module inst_feeder
    import inst_feeder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_INSNS = 16,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_rd_i,
    input  logic [31:0]         fetch_pc_i,
    output logic                fetch_accept_o,
    output logic                fetch_valid_o,
    output logic [INSN_LEN-1:0] fetch_instr_o,
    output logic [31:0]         fetch_pc_o,
    input  logic                fetch_rsp_ready_i,
    input  logic                fetch_flush_i,
    input  logic [INSN_LEN-1:0] sym_insn_i,
    output logic [INSN_LEN-1:0] chk_insn_o,
    output logic [CNT_W-1:0]    issued_cnt_o,
    output logic                budget_done_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSNS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
    logic             budget_open;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [INSN_LEN-1:0] word_sel;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head_entry;

    // Acceptance depends only on the registered full flag, so there is no
    // combinational path from fetch_rsp_ready_i to fetch_accept_o. A request
    // alongside a flush is still taken and becomes the first post-flush fetch.
    always_comb begin
        budget_open    = (issued_cnt_q < MAX_CNT);
        word_sel       = budget_open ? sym_insn_i : RV_NOP;
        fetch_accept_o = rst_n && !fifo_full;
        push           = fetch_rd_i && fetch_accept_o;
        fetch_valid_o  = !fifo_empty;
        pop            = fetch_valid_o && fetch_rsp_ready_i;
        wr_entry.pc    = fetch_pc_i;
        wr_entry.insn  = word_sel;
    end

    // Counter saturates at MAX_INSNS and survives flushes.
    always_comb begin
        issued_cnt_d = issued_cnt_q;
        if (push && budget_open) begin
            issued_cnt_d = issued_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_cnt_q <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
        end
    end

    feeder_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (fetch_flush_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_entry)
    );

    always_comb begin
        chk_insn_o    = word_sel;
        fetch_instr_o = head_entry.insn;
        fetch_pc_o    = head_entry.pc;
        issued_cnt_o  = issued_cnt_q;
        budget_done_o = (issued_cnt_q == MAX_CNT);
    end

endmodule

// File: tb/tb_inst_feeder.sv
module tb_inst_feeder;

    localparam int DEPTH     = 4;
    localparam int MAX_INSNS = 2;
    localparam int CNT_W     = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_rd_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_accept_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_rsp_ready_i;
    logic        fetch_flush_i;
    logic [31:0] sym_insn_i;
    logic [31:0] chk_insn_o;
    logic [CNT_W-1:0] issued_cnt_o;
    logic        budget_done_o;

    int errors = 0;
    int checks = 0;

    inst_feeder #(
        .DEPTH     (DEPTH),
        .MAX_INSNS (MAX_INSNS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_rd_i        (fetch_rd_i),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_accept_o    (fetch_accept_o),
        .fetch_valid_o     (fetch_valid_o),
        .fetch_instr_o     (fetch_instr_o),
        .fetch_pc_o        (fetch_pc_o),
        .fetch_rsp_ready_i (fetch_rsp_ready_i),
        .fetch_flush_i     (fetch_flush_i),
        .sym_insn_i        (sym_insn_i),
        .chk_insn_o        (chk_insn_o),
        .issued_cnt_o      (issued_cnt_o),
        .budget_done_o     (budget_done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        fetch_rd_i = 1'b0;
        fetch_flush_i = 1'b0;
        fetch_rsp_ready_i = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_rd_i = 1'b0;
        fetch_pc_i = '0;
        fetch_rsp_ready_i = 1'b0;
        fetch_flush_i = 1'b0;
        sym_insn_i = '0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_accept_low", 64'(fetch_accept_o), 64'd0);
        chk("rst_valid", 64'(fetch_valid_o), 64'd0);
        chk("rst_instr", 64'(fetch_instr_o), 64'd0);
        chk("rst_pc", 64'(fetch_pc_o), 64'd0);
        chk("rst_cnt", 64'(issued_cnt_o), 64'd0);
        chk("rst_done", 64'(budget_done_o), 64'd0);
        rst_n = 1'b1;
        settle();
        chk("post_rst_accept", 64'(fetch_accept_o), 64'd1);

        // ---- single fetch ----
        fetch_rd_i = 1'b1;
        fetch_pc_i = 32'h8000_0000;
        sym_insn_i = 32'h00A0_0093;
        settle();
        chk("single_accept", 64'(fetch_accept_o), 64'd1);
        chk("single_chk_tap", 64'(chk_insn_o), 64'h00A0_0093);
        tick();
        fetch_rd_i = 1'b0;
        settle();
        chk("single_valid", 64'(fetch_valid_o), 64'd1);
        chk("single_instr", 64'(fetch_instr_o), 64'h00A0_0093);
        chk("single_pc", 64'(fetch_pc_o), 64'h8000_0000);
        chk("single_cnt", 64'(issued_cnt_o), 64'd1);
        chk("single_done", 64'(budget_done_o), 64'd0);
        fetch_rsp_ready_i = 1'b1;
        tick();
        fetch_rsp_ready_i = 1'b0;
        settle();
        chk("single_drained", 64'(fetch_valid_o), 64'd0);
        chk("single_empty_instr", 64'(fetch_instr_o), 64'd0);

        // ---- budget: second symbolic, then NOPs ----
        fetch_rd_i = 1'b1;
        fetch_pc_i = 32'h104;
        sym_insn_i = 32'h1111_1111;
        settle();
        chk("budget_tap_open", 64'(chk_insn_o), 64'h1111_1111);
        tick();
        fetch_pc_i = 32'h108;
        sym_insn_i = 32'h2222_2222;
        settle();
        chk("budget_cnt2", 64'(issued_cnt_o), 64'd2);
        chk("budget_done", 64'(budget_done_o), 64'd1);
        chk("budget_tap_nop", 64'(chk_insn_o), 64'(NOP));
        tick();
        fetch_pc_i = 32'h10C;
        sym_insn_i = 32'h3333_3333;
        tick();
        fetch_rd_i = 1'b0;
        settle();
        chk("budget_cnt_hold", 64'(issued_cnt_o), 64'd2);
        fetch_rsp_ready_i = 1'b1;
        settle();
        chk("budget_r0_pc", 64'(fetch_pc_o), 64'h104);
        chk("budget_r0_instr", 64'(fetch_instr_o), 64'h1111_1111);
        tick();
        chk("budget_r1_pc", 64'(fetch_pc_o), 64'h108);
        chk("budget_r1_instr", 64'(fetch_instr_o), 64'(NOP));
        tick();
        chk("budget_r2_pc", 64'(fetch_pc_o), 64'h10C);
        chk("budget_r2_instr", 64'(fetch_instr_o), 64'(NOP));
        tick();
        chk("budget_drained", 64'(fetch_valid_o), 64'd0);
        fetch_rsp_ready_i = 1'b0;

        // ---- reset mid-stream ----
        do_reset();
        fetch_rd_i = 1'b1;
        fetch_pc_i = 32'h200;
        sym_insn_i = 32'hAAAA_0001;
        tick();
        fetch_pc_i = 32'h204;
        sym_insn_i = 32'hAAAA_0002;
        tick();
        fetch_rd_i = 1'b0;
        settle();
        chk("mid_cnt_before", 64'(issued_cnt_o), 64'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("mid_valid", 64'(fetch_valid_o), 64'd0);
        chk("mid_cnt", 64'(issued_cnt_o), 64'd0);
        chk("mid_done", 64'(budget_done_o), 64'd0);
        fetch_rd_i = 1'b1;
        fetch_pc_i = 32'h300;
        sym_insn_i = 32'h0BB0_0013;
        tick();
        fetch_rd_i = 1'b0;
        settle();
        chk("mid_post_pc", 64'(fetch_pc_o), 64'h300);
        chk("mid_post_instr", 64'(fetch_instr_o), 64'h0BB0_0013);

        // ---- backpressure ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch_rd_i = 1'b1;
            fetch_pc_i = 32'h1000 + 32'(4 * i);
            sym_insn_i = 32'hC000_0000 + 32'(i);
            settle();
            chk($sformatf("bp_accept_%0d", i), 64'(fetch_accept_o), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        fetch_rd_i = 1'b0;
        settle();
        chk("bp_cnt_sat", 64'(issued_cnt_o), 64'd2);
        fetch_rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("bp_valid_%0d", i), 64'(fetch_valid_o), 64'd1);
            chk($sformatf("bp_pc_%0d", i), 64'(fetch_pc_o), 64'(32'h1000 + 32'(4 * i)));
            chk($sformatf("bp_instr_%0d", i), 64'(fetch_instr_o),
                (i < 2) ? 64'(32'hC000_0000 + 32'(i)) : 64'(NOP));
            chk($sformatf("bp_accept_drain_%0d", i), 64'(fetch_accept_o), (i == 0) ? 64'd0 : 64'd1);
            tick();
        end
        chk("bp_drained", 64'(fetch_valid_o), 64'd0);
        chk("bp_accept_back", 64'(fetch_accept_o), 64'd1);
        fetch_rsp_ready_i = 1'b0;

        // ---- flush with concurrent request ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_rd_i = 1'b1;
            fetch_pc_i = 32'h40 + 32'(4 * i);
            sym_insn_i = 32'hEEEE_0000 + 32'(i);
            tick();
        end
        fetch_pc_i = 32'h100;
        sym_insn_i = 32'hDDDD_0013;
        fetch_flush_i = 1'b1;
        tick();
        fetch_flush_i = 1'b0;
        fetch_rd_i = 1'b0;
        settle();
        chk("flush_valid", 64'(fetch_valid_o), 64'd1);
        chk("flush_pc", 64'(fetch_pc_o), 64'h100);
        chk("flush_instr", 64'(fetch_instr_o), 64'(NOP));
        chk("flush_cnt_kept", 64'(issued_cnt_o), 64'd2);
        fetch_rsp_ready_i = 1'b1;
        tick();
        chk("flush_only_one", 64'(fetch_valid_o), 64'd0);
        fetch_rsp_ready_i = 1'b0;

        // ---- pointer wrap: 3*DEPTH streaming push/pop ----
        do_reset();
        fetch_rsp_ready_i = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            fetch_rd_i = 1'b1;
            fetch_pc_i = 32'h2000 + 32'(4 * i);
            sym_insn_i = 32'h5000_0000 + 32'(i);
            settle();
            chk($sformatf("wrap_accept_%0d", i), 64'(fetch_accept_o), 64'd1);
            if (i > 0) begin
                chk($sformatf("wrap_valid_%0d", i), 64'(fetch_valid_o), 64'd1);
                chk($sformatf("wrap_pc_%0d", i), 64'(fetch_pc_o), 64'(32'h2000 + 32'(4 * (i - 1))));
                chk($sformatf("wrap_instr_%0d", i), 64'(fetch_instr_o),
                    (i - 1 < 2) ? 64'(32'h5000_0000 + 32'(i - 1)) : 64'(NOP));
            end
            tick();
        end
        fetch_rd_i = 1'b0;
        settle();
        chk("wrap_last_pc", 64'(fetch_pc_o), 64'(32'h2000 + 32'(4 * (3 * DEPTH - 1))));
        tick();
        chk("wrap_drained", 64'(fetch_valid_o), 64'd0);
        fetch_rsp_ready_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
